// File: rtl/inv_butterfly.sv
// Gentleman-Sande inverse-NTT butterfly: x=(a+b) mod q, y=((a-b) mod q)*w mod q, plus MUL and ADDSUB modes.
// Latency: ADDSUB 1 cycle at 1 op/cycle; INTT/MUL NBITS cycles after accept; ready_o low while the serial multiply runs.
module inv_butterfly #(
    parameter int NBITS = 256
) (
    input  logic             hclk,
    input  logic             hresetn,
    input  logic             clr,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       mode,
    input  logic [NBITS-1:0] ar,
    input  logic [NBITS-1:0] br,
    input  logic [NBITS-1:0] wr,
    input  logic [NBITS-1:0] mod,
    output logic [NBITS-1:0] xr,
    output logic [NBITS-1:0] yr,
    output logic             done_p,
    output logic             busy
);

    localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state, state_nxt;
    logic [NBITS-1:0]   w_q, q_q, md_q, xpend;
    logic [NBITS+1:0]   acc;
    logic [CW-1:0]      cnt;
    logic               accept;

    logic [NBITS:0]     s, d;
    logic [NBITS-1:0]   sm, dm;
    logic [NBITS+1:0]   qx, t1, t1r, t2, t2r;

    assign ready_o = (state == IDLE);
    assign busy    = (state == MUL);
    assign accept  = valid_i & ready_o & ~clr;

    // Sum/difference at NBITS+1 bits so the carry/borrow drives the single correction step.
    assign s  = {1'b0, ar} + {1'b0, br};
    assign d  = {1'b0, ar} - {1'b0, br};
    assign sm = (s >= {1'b0, mod}) ? NBITS'(s - {1'b0, mod}) : s[NBITS-1:0];
    assign dm = d[NBITS] ? NBITS'(d + {1'b0, mod}) : d[NBITS-1:0];

    // One MSB-first interleaved step: double, reduce, conditionally add multiplicand, reduce.
    assign qx  = {2'b00, q_q};
    assign t1  = acc << 1;
    assign t1r = (t1 >= qx) ? t1 - qx : t1;
    assign t2  = w_q[cnt] ? t1r + {2'b00, md_q} : t1r;
    assign t2r = (t2 >= qx) ? t2 - qx : t2;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept && !mode[1]) state_nxt = MUL;
                MUL:     if (cnt == '0)          state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            xr     <= '0;
            yr     <= '0;
            done_p <= 1'b0;
            w_q    <= '0;
            q_q    <= '0;
            md_q   <= '0;
            xpend  <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (clr) begin
            done_p <= 1'b0;
        end else begin
            done_p <= 1'b0;
            if (accept) begin
                if (mode[1]) begin
                    xr     <= sm;
                    yr     <= dm;
                    done_p <= 1'b1;
                end else begin
                    xpend <= mode[0] ? br : sm;
                    md_q  <= mode[0] ? ar : dm;
                    w_q   <= wr;
                    q_q   <= mod;
                    acc   <= '0;
                    cnt   <= CW'(NBITS - 1);
                end
            end else if (state == MUL) begin
                acc <= t2r;
                cnt <= cnt - 1'b1;
                if (cnt == '0) begin
                    xr     <= xpend;
                    yr     <= t2r[NBITS-1:0];
                    done_p <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inv_butterfly.sv
// Directed bench for inv_butterfly at NBITS=8 with hand-computed modular results.
module tb_inv_butterfly;

    localparam int NB = 8;

    logic          hclk = 1'b0;
    logic          hresetn;
    logic          clr;
    logic          valid_i;
    logic          ready_o;
    logic [1:0]    mode;
    logic [NB-1:0] ar, br, wr, mod;
    logic [NB-1:0] xr, yr;
    logic          done_p;
    logic          busy;

    int n_assert = 0;
    int n_fail   = 0;

    inv_butterfly #(.NBITS(NB)) dut (
        .hclk(hclk), .hresetn(hresetn), .clr(clr), .valid_i(valid_i), .ready_o(ready_o),
        .mode(mode), .ar(ar), .br(br), .wr(wr), .mod(mod),
        .xr(xr), .yr(yr), .done_p(done_p), .busy(busy)
    );

    always #5 hclk = ~hclk;

    // Drives one op and returns 1 time unit after the accepting edge.
    task automatic start_op(input logic [1:0] m, input int a, input int b, input int w, input int q);
        mode = m; ar = NB'(a); br = NB'(b); wr = NB'(w); mod = NB'(q);
        valid_i = 1'b1;
        @(posedge hclk); #1;
        valid_i = 1'b0;
    endtask

    // Edges after accept until done_p is seen; -1 when the budget expires.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge hclk); #1;
            if (done_p) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_assert++; if (xr !== 8'd0) begin n_fail++; $display("FAIL reset_xr got %0d want 0", xr); end
        n_assert++; if (yr !== 8'd0) begin n_fail++; $display("FAIL reset_yr got %0d want 0", yr); end
        n_assert++; if (done_p !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done_p); end
        n_assert++; if (ready_o !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got ready=%b busy=%b want 1/0", ready_o, busy); end
    endtask

    task automatic test_intt();
        int cyc;
        int bad_rdy;
        bad_rdy = 0;
        cyc = -1;
        start_op(2'b00, 5, 9, 3, 17);
        n_assert++; if (ready_o !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL intt_busy_e0 got ready=%b busy=%b want 0/1", ready_o, busy); end
        for (int k = 1; k <= 8; k++) begin
            @(posedge hclk); #1;
            if (k < 8 && (ready_o !== 1'b0 || done_p !== 1'b0)) bad_rdy++;
            if (done_p === 1'b1 && cyc < 0) cyc = k;
        end
        n_assert++; if (bad_rdy !== 0) begin n_fail++; $display("FAIL intt_ready_low got %0d bad cycles want 0", bad_rdy); end
        n_assert++; if (cyc !== 8) begin n_fail++; $display("FAIL intt_latency got %0d want 8", cyc); end
        n_assert++; if (xr !== 8'd14) begin n_fail++; $display("FAIL intt_xr got %0d want 14", xr); end
        n_assert++; if (yr !== 8'd5) begin n_fail++; $display("FAIL intt_yr got %0d want 5", yr); end
        n_assert++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL intt_ready_end got %b want 1", ready_o); end
        @(posedge hclk); #1;
        n_assert++; if (done_p !== 1'b0) begin n_fail++; $display("FAIL intt_pulse_width got %b want 0", done_p); end
        n_assert++; if (xr !== 8'd14 || yr !== 8'd5) begin n_fail++; $display("FAIL intt_hold got %0d,%0d want 14,5", xr, yr); end
    endtask

    task automatic test_addsub();
        mode = 2'b10; ar = 8'd16; br = 8'd16; wr = 8'd0; mod = 8'd17; valid_i = 1'b1;
        @(posedge hclk); #1;
        n_assert++; if (done_p !== 1'b1 || xr !== 8'd15 || yr !== 8'd0) begin n_fail++; $display("FAIL addsub_1 got done=%b %0d,%0d want 1 15,0", done_p, xr, yr); end
        n_assert++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL addsub_ready1 got %b want 1", ready_o); end
        ar = 8'd0; br = 8'd1;
        @(posedge hclk); #1;
        n_assert++; if (done_p !== 1'b1 || xr !== 8'd1 || yr !== 8'd16) begin n_fail++; $display("FAIL addsub_2 got done=%b %0d,%0d want 1 1,16", done_p, xr, yr); end
        n_assert++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL addsub_ready2 got %b want 1", ready_o); end
        mode = 2'b11; ar = 8'd3; br = 8'd10;
        @(posedge hclk); #1;
        valid_i = 1'b0;
        n_assert++; if (done_p !== 1'b1 || xr !== 8'd13 || yr !== 8'd10) begin n_fail++; $display("FAIL addsub_mode11 got done=%b %0d,%0d want 1 13,10", done_p, xr, yr); end
        @(posedge hclk); #1;
        n_assert++; if (done_p !== 1'b0) begin n_fail++; $display("FAIL addsub_idle_done got %b want 0", done_p); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        start_op(2'b01, 250, 7, 250, 251);
        wait_done(cyc);
        n_assert++; if (cyc !== 8) begin n_fail++; $display("FAIL mul_latency got %0d want 8", cyc); end
        n_assert++; if (yr !== 8'd1 || xr !== 8'd7) begin n_fail++; $display("FAIL mul_251 got x=%0d y=%0d want 7,1", xr, yr); end
        n_assert++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b want 1", ready_o); end
        start_op(2'b01, 16, 3, 16, 17);
        wait_done(cyc);
        n_assert++; if (cyc !== 8) begin n_fail++; $display("FAIL b2b_latency got %0d want 8", cyc); end
        n_assert++; if (yr !== 8'd1 || xr !== 8'd3) begin n_fail++; $display("FAIL b2b_17 got x=%0d y=%0d want 3,1", xr, yr); end
    endtask

    task automatic test_disturb();
        int pulses;
        int at;
        pulses = 0;
        at = -1;
        start_op(2'b00, 5, 9, 3, 17);
        for (int k = 1; k <= 12; k++) begin
            @(posedge hclk); #1;
            if (done_p === 1'b1) begin
                pulses++;
                at = k;
            end
            if (k == 2) begin valid_i = 1'b1; ar = 8'd0; mode = 2'b10; wr = 8'd255; end
            if (k == 5) valid_i = 1'b0;
        end
        n_assert++; if (pulses !== 1 || at !== 8) begin n_fail++; $display("FAIL disturb_pulses got %0d at %0d want 1 at 8", pulses, at); end
        n_assert++; if (xr !== 8'd14 || yr !== 8'd5) begin n_fail++; $display("FAIL disturb_result got %0d,%0d want 14,5", xr, yr); end
    endtask

    task automatic test_clr();
        int cyc;
        start_op(2'b00, 1, 2, 7, 17);
        repeat (3) @(posedge hclk);
        #1 clr = 1'b1;
        @(posedge hclk); #1;
        clr = 1'b0;
        n_assert++; if (ready_o !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL clr_ready got ready=%b busy=%b want 1/0", ready_o, busy); end
        n_assert++; if (done_p !== 1'b0) begin n_fail++; $display("FAIL clr_done got %b want 0", done_p); end
        n_assert++; if (xr !== 8'd14 || yr !== 8'd5) begin n_fail++; $display("FAIL clr_hold got %0d,%0d want 14,5", xr, yr); end
        start_op(2'b00, 3, 4, 5, 17);
        wait_done(cyc);
        n_assert++; if (cyc !== 8) begin n_fail++; $display("FAIL clr_new_latency got %0d want 8", cyc); end
        n_assert++; if (xr !== 8'd7 || yr !== 8'd12) begin n_fail++; $display("FAIL clr_new_result got %0d,%0d want 7,12", xr, yr); end
    endtask

    task automatic test_async_reset();
        int cyc;
        start_op(2'b00, 5, 9, 3, 17);
        repeat (5) @(posedge hclk);
        #1 hresetn = 1'b0;
        #1;
        n_assert++; if (xr !== 8'd0 || yr !== 8'd0) begin n_fail++; $display("FAIL arst_xy got %0d,%0d want 0,0", xr, yr); end
        n_assert++; if (done_p !== 1'b0 || ready_o !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL arst_ctl got done=%b ready=%b busy=%b want 0/1/0", done_p, ready_o, busy); end
        #2 hresetn = 1'b1;
        @(posedge hclk); #1;
        start_op(2'b00, 10, 12, 0, 17);
        wait_done(cyc);
        n_assert++; if (cyc !== 8) begin n_fail++; $display("FAIL arst_latency got %0d want 8", cyc); end
        n_assert++; if (xr !== 8'd5 || yr !== 8'd0) begin n_fail++; $display("FAIL arst_w0 got %0d,%0d want 5,0", xr, yr); end
    endtask

    initial begin
        hresetn = 1'b0; clr = 1'b0; valid_i = 1'b0; mode = 2'b00;
        ar = '0; br = '0; wr = '0; mod = 8'd17;
        #3;
        test_reset();
        #9 hresetn = 1'b1;
        @(posedge hclk); #1;
        test_intt();
        test_addsub();
        test_back_to_back();
        test_disturb();
        test_clr();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_butterfly.md
Name: inv_butterfly

Overview:
Gentleman-Sande (decimation-in-frequency) butterfly for the inverse NTT datapath. It computes x = (a+b) mod q and y = ((a-b) mod q)·w mod q. It pairs with the forward Cooley-Tukey butterfly in the multiplier pool and connects to the same operand, modulus and twiddle buses. Modular multiplication is done internally with a bit-serial interleaved (MSB-first) shift-add reducer, so the block has no dependency on an external multiplier.

Parameters:
NBITS, 256, operand/modulus width; minimum 4.

Ports:
hclk  in  1  clock
hresetn  in  1  asynchronous active-low reset
clr  in  1  synchronous flush; aborts any operation, returns to IDLE
valid_i  in  1  operand valid; accepted when valid_i & ready_o
ready_o  out  1  high only in IDLE
mode  in  2  00 INTT butterfly, 01 MUL (y=a·w mod q, x=b), 10 ADDSUB (x=(a+b) mod q, y=(a-b) mod q), 11 treated as 10
ar  in  NBITS  operand a, required < mod
br  in  NBITS  operand b, required < mod
wr  in  NBITS  twiddle/multiplier w, required < mod
mod  in  NBITS  modulus q, 2 ≤ q < 2^NBITS
xr  out  NBITS  result x, registered
yr  out  NBITS  result y, registered
done_p  out  1  one-cycle pulse: xr/yr updated
busy  out  1  high in MUL state (= ~ready_o)

Behaviour:
- Reset (async, hresetn=0): state IDLE; xr=0, yr=0, done_p=0, ready_o=1, busy=0; internal acc/cnt/latches = 0.
- Reset mid-operation: the operation is abandoned with no done_p. xr/yr read 0.
- Accept edge E0 (valid_i & ready_o & ~clr): latch mode, wr, mod, br.
- Also at E0, compute s = a+b and d = a-b at NBITS+1 bits.
  - sm = s-q if s ≥ q, else s.
  - dm = d+q if d < 0 (borrow), else d.
- ADDSUB (mode 1x): at E0, xr←sm, yr←dm, done_p←1. State stays IDLE and ready_o stays 1, so throughput is 1 op/cycle.
- INTT / MUL: at E0, latch xr_pend (sm for 00, b for 01).
  - Multiplicand m_d is dm for 00 and a for 01.
  - acc←0, cnt←NBITS-1, state←MUL, ready_o←0.
- MUL state, edges E1..E_NBITS: one iteration per edge.
  - t = 2·acc, reduced by one conditional subtraction of q.
  - If w[cnt]=1: t = t+m_d, reduced by one conditional subtraction of q.
  - acc←t; cnt←cnt-1.
  - Internal width is NBITS+2, so there is no overflow.
- At edge E_NBITS (cnt==0): yr←final t, xr←xr_pend, done_p←1, state←IDLE, ready_o←1.
  - Latency: done_p is high in the cycle after E_NBITS.
  - A new op can be accepted at E_NBITS+1 (back-to-back).
- done_p is exactly one cycle wide. It is 0 on every other edge, including while idle.
- xr and yr hold their values until the next completion.
- valid_i while busy is ignored; there is no queueing and no error flag.
- Changes to mode, ar, br, wr or mod after E0 have no effect on the in-flight op.
- clr=1 at any edge:
  - state←IDLE, done_p←0, ready_o←1; xr/yr are not modified.
  - clr has priority over accept and over completion in the same cycle.
- Out-of-range inputs (operand ≥ q): the result is unspecified, but the block must still complete with the normal latency. It never hangs.
- Results always satisfy 0 ≤ xr, yr < q for legal inputs.

Test Plan:
1. NBITS=8, q=17, mode 00, a=5, b=9, w=3 -> done_p 8 cycles after accept; xr=14, yr=5 ((-4 mod 17)=13, 13·3=39 mod 17=5); ready_o low for cycles E1..E7.
2. NBITS=8, q=17, mode 10, a=16, b=16, then next cycle a=0, b=1 -> done_p on two consecutive cycles; first (xr,yr)=(15,0), then (1,16); ready_o stays high throughout.
3. NBITS=8, q=251, mode 01, a=250, b=7, w=250 -> yr=1, xr=7. Then q=17, a=16, w=16 back-to-back at E9 -> yr=1, xr=b.
4. Mid-op disturbance: start mode 00 (q=17, a=5, b=9, w=3), toggle valid_i/ar/mode at E3 -> result unchanged (14, 5), single done_p.
5. clr at E4 of a mode-00 op -> no done_p; xr/yr keep previous values; ready_o=1 next cycle. A new op accepted at E5 then completes correctly.
6. Async reset asserted at E5 of an op -> xr=yr=0, done_p=0, ready_o=1 immediately. After release, mode 00 with w=0 -> yr=0, xr=(a+b) mod q.
